// File: rtl/uram_rw_arbiter_if.sv
// Client and memory-side signals of the shared URAM arbiter.
// slave = arbiter side, master = clients plus memory model.
interface uram_rw_arbiter_if #(
    parameter int DATA_WIDTH    = 64,
    parameter int ADDRESS_WIDTH = 12
);
    logic                     init_done;
    logic                     rd_valid_0;
    logic                     rd_valid_1;
    logic                     rd_ready_0;
    logic                     rd_ready_1;
    logic [ADDRESS_WIDTH-1:0] rd_addr_0;
    logic [ADDRESS_WIDTH-1:0] rd_addr_1;
    logic                     rd_resp_valid_0;
    logic                     rd_resp_valid_1;
    logic [DATA_WIDTH-1:0]    rd_resp_data;
    logic                     wr_valid_0;
    logic                     wr_valid_1;
    logic                     wr_ready_0;
    logic                     wr_ready_1;
    logic [ADDRESS_WIDTH-1:0] wr_addr_0;
    logic [ADDRESS_WIDTH-1:0] wr_addr_1;
    logic [DATA_WIDTH-1:0]    wr_data_0;
    logic [DATA_WIDTH-1:0]    wr_data_1;
    logic [ADDRESS_WIDTH-1:0] mem_raddr;
    logic [DATA_WIDTH-1:0]    mem_dout;
    logic                     mem_wen;
    logic [ADDRESS_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0]    mem_din;

    modport slave (
        input  rd_valid_0, rd_valid_1, rd_addr_0, rd_addr_1,
        input  wr_valid_0, wr_valid_1, wr_addr_0, wr_addr_1,
        input  wr_data_0, wr_data_1, mem_dout,
        output init_done, rd_ready_0, rd_ready_1,
        output rd_resp_valid_0, rd_resp_valid_1, rd_resp_data,
        output wr_ready_0, wr_ready_1,
        output mem_raddr, mem_wen, mem_waddr, mem_din
    );

    modport master (
        output rd_valid_0, rd_valid_1, rd_addr_0, rd_addr_1,
        output wr_valid_0, wr_valid_1, wr_addr_0, wr_addr_1,
        output wr_data_0, wr_data_1, mem_dout,
        input  init_done, rd_ready_0, rd_ready_1,
        input  rd_resp_valid_0, rd_resp_valid_1, rd_resp_data,
        input  wr_ready_0, wr_ready_1,
        input  mem_raddr, mem_wen, mem_waddr, mem_din
    );
endinterface

// File: rtl/uram_rw_arbiter.sv
// Two-reader/two-writer round-robin arbiter in front of a simple-dual-port
// URAM; zero-fills the memory after reset, routes read data by tag.
module uram_rw_arbiter #(
    parameter int DATA_WIDTH    = 64,
    parameter int ADDRESS_WIDTH = 12,
    parameter int READ_LATENCY  = 2
) (
    input  logic               clock,
    input  logic               reset,
    uram_rw_arbiter_if.slave   bus
);
    typedef enum logic {CLEAR, RUN} state_t;

    state_t                   state;
    logic [ADDRESS_WIDTH-1:0] fill_cnt;
    logic                     init_q;
    logic                     rd_ptr;
    logic                     wr_ptr;
    logic [ADDRESS_WIDTH-1:0] raddr_q;
    logic [READ_LATENCY-1:0]  tag_vld;
    logic [READ_LATENCY-1:0]  tag_id;

    logic run;
    logic clear;
    logic rd_g0, rd_g1, rd_hs;
    logic wr_g0, wr_g1, wr_hs;

    // Reset gates everything combinationally so nothing leaks during reset.
    assign run   = (state == RUN) && !reset;
    assign clear = (state == CLEAR) && !reset;

    assign rd_g0 = run && bus.rd_valid_0 && (!bus.rd_valid_1 || !rd_ptr);
    assign rd_g1 = run && bus.rd_valid_1 && (!bus.rd_valid_0 || rd_ptr);
    assign rd_hs = rd_g0 || rd_g1;

    assign wr_g0 = run && bus.wr_valid_0 && (!bus.wr_valid_1 || !wr_ptr);
    assign wr_g1 = run && bus.wr_valid_1 && (!bus.wr_valid_0 || wr_ptr);
    assign wr_hs = wr_g0 || wr_g1;

    assign bus.rd_ready_0 = rd_g0;
    assign bus.rd_ready_1 = rd_g1;
    assign bus.wr_ready_0 = wr_g0;
    assign bus.wr_ready_1 = wr_g1;
    assign bus.init_done  = init_q;

    assign bus.mem_raddr = rd_g1 ? bus.rd_addr_1 :
                           rd_g0 ? bus.rd_addr_0 : raddr_q;

    assign bus.mem_wen   = clear || wr_hs;
    assign bus.mem_waddr = clear ? fill_cnt :
                           wr_g1 ? bus.wr_addr_1 : bus.wr_addr_0;
    assign bus.mem_din   = clear ? '0 :
                           wr_g1 ? bus.wr_data_1 : bus.wr_data_0;

    assign bus.rd_resp_valid_0 = !reset && tag_vld[READ_LATENCY-1]
                                 && !tag_id[READ_LATENCY-1];
    assign bus.rd_resp_valid_1 = !reset && tag_vld[READ_LATENCY-1]
                                 && tag_id[READ_LATENCY-1];
    assign bus.rd_resp_data    = bus.mem_dout;

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= CLEAR;
            fill_cnt <= '0;
            init_q   <= 1'b0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            raddr_q  <= '0;
            tag_vld  <= '0;
            tag_id   <= '0;
        end else begin
            unique case (state)
                CLEAR: begin
                    fill_cnt <= fill_cnt + ADDRESS_WIDTH'(1);
                    if (&fill_cnt) begin
                        state  <= RUN;
                        init_q <= 1'b1;
                    end
                end
                RUN: ;
            endcase
            if (rd_hs) begin
                rd_ptr  <= !rd_g1;
                raddr_q <= bus.mem_raddr;
            end
            if (wr_hs)
                wr_ptr <= !wr_g1;
            // Tag shift register mirrors the memory's read latency.
            tag_vld[0] <= rd_hs;
            tag_id[0]  <= rd_g1;
            for (int i = 1; i < READ_LATENCY; i++) begin
                tag_vld[i] <= tag_vld[i-1];
                tag_id[i]  <= tag_id[i-1];
            end
        end
    end
endmodule

// File: tb/tb_uram_rw_arbiter.sv
// Directed vector bench for uram_rw_arbiter with a read-first
// two-cycle-latency memory model on the memory side.
module tb_uram_rw_arbiter;
    localparam int DW = 64;
    localparam int AW = 4;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    uram_rw_arbiter_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();

    uram_rw_arbiter #(
        .DATA_WIDTH(DW),
        .ADDRESS_WIDTH(AW),
        .READ_LATENCY(2)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] p1;

    always @(posedge clock) begin
        if (bus.mem_wen)
            mem[bus.mem_waddr] <= bus.mem_din;
        p1           <= mem[bus.mem_raddr];
        bus.mem_dout <= p1;
    end

    typedef struct {
        logic          rv0, rv1;
        logic [AW-1:0] ra0, ra1;
        logic          wv0, wv1;
        logic [AW-1:0] wa0, wa1;
        logic [DW-1:0] wd0, wd1;
        logic          er0, er1, ew0, ew1;
        logic          ep0, ep1;
        logic [DW-1:0] edata;
        logic [AW-1:0] eraddr;
        logic [AW-1:0] ewaddr;
        logic [DW-1:0] ewdin;
    } vec_t;

    vec_t vq[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.rd_valid_0 = v.rv0;
        bus.rd_valid_1 = v.rv1;
        bus.rd_addr_0  = v.ra0;
        bus.rd_addr_1  = v.ra1;
        bus.wr_valid_0 = v.wv0;
        bus.wr_valid_1 = v.wv1;
        bus.wr_addr_0  = v.wa0;
        bus.wr_addr_1  = v.wa1;
        bus.wr_data_0  = v.wd0;
        bus.wr_data_1  = v.wd1;
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    initial begin
        // rv0 rv1 ra0 ra1 wv0 wv1 wa0 wa1 wd0 wd1 | er0 er1 ew0 ew1 ep0 ep1 data raddr waddr wdin
        vq.push_back('{1,0,5,0, 0,0,0,0,0,0,       1,0,0,0, 0,0,0,     5,0,0});
        vq.push_back('{0,0,0,0, 1,0,3,0,'hAA,0,    0,0,1,0, 0,0,0,     5,3,'hAA});
        vq.push_back('{0,1,0,3, 0,0,0,0,0,0,       0,1,0,0, 1,0,0,     3,0,0});
        vq.push_back('{0,0,0,0, 0,0,0,0,0,0,       0,0,0,0, 0,0,0,     3,0,0});
        vq.push_back('{0,0,0,0, 0,0,0,0,0,0,       0,0,0,0, 0,1,'hAA,  3,0,0});
        vq.push_back('{0,0,0,0, 1,0,1,0,'h11,0,    0,0,1,0, 0,0,0,     3,1,'h11});
        vq.push_back('{0,0,0,0, 0,1,0,2,0,'h22,    0,0,0,1, 0,0,0,     3,2,'h22});
        vq.push_back('{1,1,1,2, 0,0,0,0,0,0,       1,0,0,0, 0,0,0,     1,0,0});
        vq.push_back('{1,1,1,2, 0,0,0,0,0,0,       0,1,0,0, 0,0,0,     2,0,0});
        vq.push_back('{1,1,1,2, 0,0,0,0,0,0,       1,0,0,0, 1,0,'h11,  1,0,0});
        vq.push_back('{1,1,1,2, 0,0,0,0,0,0,       0,1,0,0, 0,1,'h22,  2,0,0});
        vq.push_back('{1,1,1,2, 0,0,0,0,0,0,       1,0,0,0, 1,0,'h11,  1,0,0});
        vq.push_back('{1,1,1,2, 0,0,0,0,0,0,       0,1,0,0, 0,1,'h22,  2,0,0});
        vq.push_back('{1,0,7,0, 1,0,7,0,'h55,0,    1,0,1,0, 1,0,'h11,  7,7,'h55});
        vq.push_back('{1,0,7,0, 0,1,0,10,0,'h33,   1,0,0,1, 0,1,'h22,  7,10,'h33});
        vq.push_back('{0,0,0,0, 1,1,9,9,1,2,       0,0,1,0, 1,0,0,     7,9,1});
        vq.push_back('{0,0,0,0, 0,1,0,9,0,2,       0,0,0,1, 1,0,'h55,  7,9,2});
        vq.push_back('{0,1,0,10, 0,0,0,0,0,0,      0,1,0,0, 0,0,0,     10,0,0});
        vq.push_back('{1,0,9,0, 0,0,0,0,0,0,       1,0,0,0, 0,0,0,     9,0,0});
        vq.push_back('{0,0,0,0, 0,0,0,0,0,0,       0,0,0,0, 0,1,'h33,  9,0,0});
        vq.push_back('{0,0,0,0, 0,0,0,0,0,0,       0,0,0,0, 1,0,2,     9,0,0});
        vq.push_back('{0,0,0,0, 0,0,0,0,0,0,       0,0,0,0, 0,0,0,     9,0,0});

        reset = 1'b1;
        drive('{default: '0});
        bus.rd_valid_0 = 1'b1;
        repeat (2) next_cycle();
        @(negedge clock);
        chk("rst init_done", bus.init_done, 0);
        chk("rst rd_ready_0", bus.rd_ready_0, 0);
        chk("rst resp_valid_0", bus.rd_resp_valid_0, 0);
        chk("rst resp_valid_1", bus.rd_resp_valid_1, 0);
        next_cycle();
        reset = 1'b0;
        bus.wr_valid_1 = 1'b1;

        for (int i = 0; i < 2**AW; i++) begin
            @(negedge clock);
            chk($sformatf("fill%0d wen", i), bus.mem_wen, 1);
            chk($sformatf("fill%0d waddr", i), bus.mem_waddr, i);
            chk($sformatf("fill%0d din", i), bus.mem_din, 0);
            chk($sformatf("fill%0d init_done", i), bus.init_done, 0);
            chk($sformatf("fill%0d rd_ready_0", i), bus.rd_ready_0, 0);
            chk($sformatf("fill%0d wr_ready_1", i), bus.wr_ready_1, 0);
            next_cycle();
        end

        foreach (vq[i]) begin
            drive(vq[i]);
            @(negedge clock);
            chk($sformatf("v%0d init_done", i), bus.init_done, 1);
            chk($sformatf("v%0d rd_ready_0", i), bus.rd_ready_0, vq[i].er0);
            chk($sformatf("v%0d rd_ready_1", i), bus.rd_ready_1, vq[i].er1);
            chk($sformatf("v%0d wr_ready_0", i), bus.wr_ready_0, vq[i].ew0);
            chk($sformatf("v%0d wr_ready_1", i), bus.wr_ready_1, vq[i].ew1);
            chk($sformatf("v%0d mem_wen", i), bus.mem_wen,
                vq[i].ew0 | vq[i].ew1);
            chk($sformatf("v%0d resp_valid_0", i), bus.rd_resp_valid_0,
                vq[i].ep0);
            chk($sformatf("v%0d resp_valid_1", i), bus.rd_resp_valid_1,
                vq[i].ep1);
            chk($sformatf("v%0d mem_raddr", i), bus.mem_raddr, vq[i].eraddr);
            if (vq[i].ew0 | vq[i].ew1) begin
                chk($sformatf("v%0d mem_waddr", i), bus.mem_waddr,
                    vq[i].ewaddr);
                chk($sformatf("v%0d mem_din", i), bus.mem_din, vq[i].ewdin);
            end
            if (vq[i].ep0 | vq[i].ep1)
                chk($sformatf("v%0d resp_data", i), bus.rd_resp_data,
                    vq[i].edata);
            next_cycle();
        end

        // Read accepted, then reset: its response must never appear.
        drive('{default: '0});
        bus.rd_valid_0 = 1'b1;
        bus.rd_addr_0  = 5;
        @(negedge clock);
        chk("mid rd_ready_0", bus.rd_ready_0, 1);
        next_cycle();
        reset = 1'b1;
        @(negedge clock);
        chk("mid rst rd_ready_0", bus.rd_ready_0, 0);
        chk("mid rst resp_valid_0", bus.rd_resp_valid_0, 0);
        next_cycle();
        reset = 1'b0;
        for (int i = 0; i < 2**AW; i++) begin
            @(negedge clock);
            chk($sformatf("refill%0d waddr", i), bus.mem_waddr, i);
            chk($sformatf("refill%0d wen", i), bus.mem_wen, 1);
            chk($sformatf("refill%0d init_done", i), bus.init_done, 0);
            chk($sformatf("refill%0d rd_ready_0", i), bus.rd_ready_0, 0);
            chk($sformatf("refill%0d resp_valid_0", i),
                bus.rd_resp_valid_0, 0);
            chk($sformatf("refill%0d resp_valid_1", i),
                bus.rd_resp_valid_1, 0);
            next_cycle();
        end
        bus.rd_valid_0 = 1'b0;
        @(negedge clock);
        chk("refill done init_done", bus.init_done, 1);
        chk("refill done resp_valid_0", bus.rd_resp_valid_0, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule

// File: doc/uram_rw_arbiter.md
Name: uram_rw_arbiter

Overview:
- Shares one simple-dual-port URAM-style memory (one read port, one write port, fixed read latency) between two read clients and two write clients.
- Zero-fills the whole memory after reset; clients are served only after the fill completes.
- Arbitrates reads and writes independently, each with its own round-robin pointer.
- Returns each read's data to its requester at the memory's fixed read latency; responses are routed by a tag pipeline.

Parameters:
- DATA_WIDTH, 64, memory word width.
- ADDRESS_WIDTH, 12, memory address width; depth is 2^ADDRESS_WIDTH.
- READ_LATENCY, 2, memory read latency in cycles; legal values are 1 and 2.

Ports:
- clock  in  1  sole clock.
- reset  in  1  synchronous, active-high reset.
- init_done  out  1  high once the zero-fill has completed.
- rd_valid_0, rd_valid_1  in  1  read request valid, per client.
- rd_ready_0, rd_ready_1  out  1  read request accepted, per client.
- rd_addr_0, rd_addr_1  in  ADDRESS_WIDTH  read address, per client.
- rd_resp_valid_0, rd_resp_valid_1  out  1  read data valid, per client.
- rd_resp_data  out  DATA_WIDTH  read data, shared by both clients.
- wr_valid_0, wr_valid_1  in  1  write request valid, per client.
- wr_ready_0, wr_ready_1  out  1  write accepted, per client.
- wr_addr_0, wr_addr_1  in  ADDRESS_WIDTH  write address, per client.
- wr_data_0, wr_data_1  in  DATA_WIDTH  write data, per client.
- mem_raddr  out  ADDRESS_WIDTH  memory read address.
- mem_dout  in  DATA_WIDTH  memory read data.
- mem_wen  out  1  memory write enable.
- mem_waddr  out  ADDRESS_WIDTH  memory write address.
- mem_din  out  DATA_WIDTH  memory write data.

Behaviour:
- Reset state (synchronous, active-high; clock is the only clock):
  - FSM=CLEAR, fill counter=0, both round-robin pointers=client 0.
  - Tag pipeline valids all 0; init_done=0.
  - All rd_ready, wr_ready and rd_resp_valid are 0 while reset is high.
- FSM has two states, CLEAR and RUN.
- CLEAR:
  - Every cycle: mem_wen=1, mem_waddr=counter, mem_din=0, counter increments.
  - The cycle that writes address 2^ADDRESS_WIDTH-1 is the last; next state is RUN. CLEAR lasts exactly 2^ADDRESS_WIDTH cycles.
  - All client readies are 0. mem_raddr is don't-care.
- RUN:
  - init_done=1 (registered; rises the first RUN cycle).
  - RUN persists until reset.
- Read arbitration:
  - Combinational from the rd_valid inputs and the read pointer.
  - Exactly one valid client: that client is granted.
  - Both valid: the client the pointer selects is granted.
  - Only the granted client sees rd_ready=1. A handshake is valid&ready.
  - After a handshake, the pointer moves to the other client. With no handshake, the pointer holds.
  - mem_raddr = granted client's address. With no grant, mem_raddr holds the last granted value.
- Write arbitration:
  - Identical scheme with a separate pointer.
  - mem_wen = write handshake (combinational); mem_waddr/mem_din come from the granted client.
- Read and write arbitration are independent: one read and one write may be accepted in the same cycle.
- Response pipeline:
  - READ_LATENCY-stage shift register of {valid, client id}, loaded on each read handshake.
  - rd_resp_valid_i is asserted exactly READ_LATENCY cycles after client i's handshake.
  - rd_resp_data is mem_dout passed through unregistered.
  - Responses have no backpressure; one read per cycle gives full throughput.
- Hazards (memory is read-first):
  - A read accepted in the same cycle as a write to the same address returns the old data.
  - A read accepted one or more cycles after the write returns the new data.
  - Writes from both clients to the same address land in grant order; the later write wins.
- Requesters must hold valid/addr/data stable until their handshake. The arbiter does not check this.
- Reset mid-operation:
  - In-flight responses are discarded; no rd_resp_valid is ever issued for them.
  - FSM restarts CLEAR from address 0.

Test Plan:
- ADDRESS_WIDTH=4 (16 words), reset pulse → mem_wen=1 for 16 cycles with mem_waddr 0..15 and mem_din=0; init_done=1 on cycle 17; read of addr 5 returns 0.
- Client 0 writes addr 3 = 0xAA; client 1 reads addr 3 the next cycle → rd_resp_valid_1 exactly 2 cycles later, rd_resp_data=0xAA, rd_resp_valid_0 stays 0.
- Both read clients valid for 6 cycles (addr 1 and addr 2, preloaded 0x11/0x22) → grants 0,1,0,1,0,1; responses alternate 0x11/0x22, one per cycle, with no gaps.
- Same-cycle write of addr 7 = 0x55 and read of addr 7 (old value 0) → response 0; a read issued the next cycle returns 0x55.
- Both write clients valid in the same cycle, addr 9 (client 0 data 0x1, client 1 data 0x2) → client 0 accepted first, client 1 one cycle later; a later read of addr 9 returns 0x2.
- Reset asserted one cycle after a read handshake → no rd_resp_valid ever appears; mem_waddr restarts at 0; init_done=0 until the fill completes.
